// File: rtl/vx_tex_addr_gen_if.sv
// Request/response bundle for the texture address stage, including the stage select
// and the per-stage DCR state returned by the DCR block.
interface vx_tex_addr_gen_if #(
  parameter int unsigned NUM_LANES   = 4,
  parameter int unsigned ADDR_BITS   = 32,
  parameter int unsigned TAG_WIDTH   = 8,
  parameter int unsigned STAGE_BITS  = 2,
  parameter int unsigned LOD_BITS    = 3,
  parameter int unsigned LOD_MAX     = 5,
  parameter int unsigned FMT_BITS    = 3,
  parameter int unsigned LOGDIM_BITS = 5
);

  // logdims[0]/wraps[0] apply to u, index 1 to v.
  typedef struct packed {
    logic [ADDR_BITS-1:0]                baseaddr;
    logic [LOD_MAX:0][ADDR_BITS-1:0]     mipoff;
    logic [1:0][LOGDIM_BITS-1:0]         logdims;
    logic [1:0][1:0]                     wraps;
    logic [FMT_BITS-1:0]                 format;
  } tex_dcrs_t;

  logic                           req_valid;
  logic                           req_ready;
  logic [STAGE_BITS-1:0]          req_stage;
  logic [LOD_BITS-1:0]            req_lod;
  logic [NUM_LANES*32-1:0]        req_u;
  logic [NUM_LANES*32-1:0]        req_v;
  logic [TAG_WIDTH-1:0]           req_tag;

  logic [STAGE_BITS-1:0]          stage;
  tex_dcrs_t                      tex_dcrs;

  logic                           rsp_valid;
  logic                           rsp_ready;
  logic [NUM_LANES*ADDR_BITS-1:0] rsp_addr;
  logic [TAG_WIDTH-1:0]           rsp_tag;

  modport master (
    output req_valid, req_stage, req_lod, req_u, req_v, req_tag, tex_dcrs, rsp_ready,
    input  req_ready, stage, rsp_valid, rsp_addr, rsp_tag
  );

  modport slave (
    input  req_valid, req_stage, req_lod, req_u, req_v, req_tag, tex_dcrs, rsp_ready,
    output req_ready, stage, rsp_valid, rsp_addr, rsp_tag
  );

endinterface

// File: rtl/vx_tex_addr_gen.sv
// Texture address stage: wrap modes and mip selection, producing per-lane texel byte
// addresses through an elastic 2-deep valid/ready pipeline.
module vx_tex_addr_gen #(
  parameter int unsigned NUM_LANES   = 4,
  parameter int unsigned FRAC_BITS   = 20,
  parameter int unsigned ADDR_BITS   = 32,
  parameter int unsigned TAG_WIDTH   = 8,
  parameter int unsigned STAGE_BITS  = 2,
  parameter int unsigned LOD_BITS    = 3,
  parameter int unsigned LOD_MAX     = 5,
  parameter int unsigned FMT_BITS    = 3,
  parameter int unsigned LOGDIM_BITS = 5
) (
  input logic               clk,
  input logic               reset,
  vx_tex_addr_gen_if.slave  bus
);

  localparam int unsigned LogW = $clog2(FRAC_BITS + 1);

  localparam logic [1:0] WrapRepeat = 2'd1;
  localparam logic [1:0] WrapMirror = 2'd2;

  // Wrap one coordinate to a FRAC_BITS fraction; codes 0 and 3 both clamp.
  function automatic logic [FRAC_BITS-1:0] wrap_coord(input logic [31:0] c,
                                                      input logic [1:0]  mode);
    logic [FRAC_BITS-1:0] f;
    f = c[FRAC_BITS-1:0];
    case (mode)
      WrapRepeat: return f;
      WrapMirror: return c[FRAC_BITS] ? ~f : f;
      default: begin
        if (c[31])                        return '0;
        else if (c[31:FRAC_BITS] != '0)   return '1;
        else                              return f;
      end
    endcase
  endfunction

  // Clamp the dimension to FRAC_BITS, then drop lodc levels, saturating at zero.
  function automatic logic [LogW-1:0] axis_log(input logic [LOGDIM_BITS-1:0] logdim,
                                               input logic [LOD_BITS-1:0]    lodc);
    logic [LOGDIM_BITS-1:0] ld;
    logic [LOGDIM_BITS-1:0] lx;
    ld = (logdim > LOGDIM_BITS'(FRAC_BITS)) ? LOGDIM_BITS'(FRAC_BITS) : logdim;
    lx = LOGDIM_BITS'(lodc);
    return (ld > lx) ? LogW'(ld - lx) : '0;
  endfunction

  function automatic logic [1:0] format_stride(input logic [FMT_BITS-1:0] fmt);
    case (fmt)
      FMT_BITS'(1), FMT_BITS'(2), FMT_BITS'(3), FMT_BITS'(4): return 2'd1;
      FMT_BITS'(5), FMT_BITS'(6):                             return 2'd0;
      default:                                                return 2'd2;
    endcase
  endfunction

  // S1 state
  logic                                 s1_valid_q, s1_valid_d;
  logic [TAG_WIDTH-1:0]                 s1_tag_q, s1_tag_d;
  logic [ADDR_BITS-1:0]                 s1_mbase_q, s1_mbase_d;
  logic [LogW-1:0]                      s1_logw_q, s1_logw_d;
  logic [LogW-1:0]                      s1_logh_q, s1_logh_d;
  logic [1:0]                           s1_lstride_q, s1_lstride_d;
  logic [NUM_LANES-1:0][FRAC_BITS-1:0]  s1_fu_q, s1_fu_d;
  logic [NUM_LANES-1:0][FRAC_BITS-1:0]  s1_fv_q, s1_fv_d;

  // S2 / output state
  logic                                 rsp_valid_q, rsp_valid_d;
  logic [TAG_WIDTH-1:0]                 rsp_tag_q, rsp_tag_d;
  logic [NUM_LANES*ADDR_BITS-1:0]       rsp_addr_q, rsp_addr_d;

  logic                                 s2_ready;
  logic                                 s1_advance;
  logic                                 req_ready;
  logic                                 accept;
  logic [LOD_BITS-1:0]                  lodc;
  logic [LogW-1:0]                      shift_u, shift_v;
  logic [ADDR_BITS-1:0]                 lane_x [NUM_LANES];
  logic [ADDR_BITS-1:0]                 lane_y [NUM_LANES];

  assign s2_ready   = !rsp_valid_q || bus.rsp_ready;
  assign s1_advance = s1_valid_q && s2_ready;
  assign req_ready  = !s1_valid_q || s1_advance;
  assign accept     = bus.req_valid && req_ready;

  assign bus.req_ready = req_ready;
  assign bus.stage     = bus.req_stage;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_tag   = rsp_tag_q;
  assign bus.rsp_addr  = rsp_addr_q;

  // S1: sample the DCR state of the selected stage together with the request.
  always_comb begin
    lodc = (bus.req_lod > LOD_BITS'(LOD_MAX)) ? LOD_BITS'(LOD_MAX) : bus.req_lod;

    s1_valid_d   = s1_valid_q;
    s1_tag_d     = s1_tag_q;
    s1_mbase_d   = s1_mbase_q;
    s1_logw_d    = s1_logw_q;
    s1_logh_d    = s1_logh_q;
    s1_lstride_d = s1_lstride_q;
    s1_fu_d      = s1_fu_q;
    s1_fv_d      = s1_fv_q;

    if (accept) begin
      s1_valid_d   = 1'b1;
      s1_tag_d     = bus.req_tag;
      s1_mbase_d   = bus.tex_dcrs.baseaddr + bus.tex_dcrs.mipoff[lodc];
      s1_logw_d    = axis_log(bus.tex_dcrs.logdims[0], lodc);
      s1_logh_d    = axis_log(bus.tex_dcrs.logdims[1], lodc);
      s1_lstride_d = format_stride(bus.tex_dcrs.format);
      for (int i = 0; i < NUM_LANES; i++) begin
        s1_fu_d[i] = wrap_coord(bus.req_u[i*32 +: 32], bus.tex_dcrs.wraps[0]);
        s1_fv_d[i] = wrap_coord(bus.req_v[i*32 +: 32], bus.tex_dcrs.wraps[1]);
      end
    end else if (s1_advance) begin
      s1_valid_d = 1'b0;
    end
  end

  // S2: texel coordinates from the top log2(dim) fraction bits, then the byte address.
  always_comb begin
    shift_u = LogW'(FRAC_BITS) - s1_logw_q;
    shift_v = LogW'(FRAC_BITS) - s1_logh_q;

    rsp_valid_d = s2_ready ? s1_valid_q : rsp_valid_q;
    rsp_tag_d   = rsp_tag_q;
    rsp_addr_d  = rsp_addr_q;

    for (int i = 0; i < NUM_LANES; i++) begin
      lane_x[i] = ADDR_BITS'(s1_fu_q[i] >> shift_u);
      lane_y[i] = ADDR_BITS'(s1_fv_q[i] >> shift_v);
    end

    if (s1_advance) begin
      rsp_tag_d = s1_tag_q;
      for (int i = 0; i < NUM_LANES; i++) begin
        rsp_addr_d[i*ADDR_BITS +: ADDR_BITS] =
          s1_mbase_q + (((lane_y[i] << s1_logw_q) + lane_x[i]) << s1_lstride_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid_q   <= 1'b0;
      s1_tag_q     <= '0;
      s1_mbase_q   <= '0;
      s1_logw_q    <= '0;
      s1_logh_q    <= '0;
      s1_lstride_q <= '0;
      s1_fu_q      <= '0;
      s1_fv_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_tag_q    <= '0;
      rsp_addr_q   <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_tag_q     <= s1_tag_d;
      s1_mbase_q   <= s1_mbase_d;
      s1_logw_q    <= s1_logw_d;
      s1_logh_q    <= s1_logh_d;
      s1_lstride_q <= s1_lstride_d;
      s1_fu_q      <= s1_fu_d;
      s1_fv_q      <= s1_fv_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_tag_q    <= rsp_tag_d;
      rsp_addr_q   <= rsp_addr_d;
    end
  end

endmodule
